// File: rtl/soc_perf_pkg.sv
// ============================================================================
// Module   : soc_perf_pkg
// Purpose  : Register map, CTRL bit layout and ID magic for the perf counter bank.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package soc_perf_pkg;

    localparam logic [8:0] c_addr_ctrl       = 9'h000;
    localparam logic [8:0] c_addr_enable     = 9'h001;
    localparam logic [8:0] c_addr_mode       = 9'h002;
    localparam logic [8:0] c_addr_ovf        = 9'h003;
    localparam logic [8:0] c_addr_irq_mask   = 9'h004;
    localparam logic [8:0] c_addr_id         = 9'h005;
    localparam logic [8:0] c_addr_count_base = 9'h010;
    localparam logic [8:0] c_addr_snap_base  = 9'h020;

    localparam int c_ctrl_gen_bit  = 0;
    localparam int c_ctrl_snap_bit = 1;
    localparam int c_ctrl_clr_bit  = 2;

    localparam logic [15:0] c_id_magic = 16'h5043;

    typedef struct packed {
        logic clr;
        logic snap;
        logic gen;
    } ctrl_reg_t;

endpackage

`default_nettype wire

// File: rtl/perf_counter_channel.sv
// ============================================================================
// Module   : perf_counter_channel
// Purpose  : One event counter: level/edge qualify, load, clear, wrap with overflow pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module perf_counter_channel #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             event_in,
    input  logic             count_en,
    input  logic             edge_mode,
    input  logic             load,
    input  logic [CNT_W-1:0] load_data,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             ovf_pulse
);

    logic             r_prev;
    logic [CNT_W-1:0] r_count;
    logic             w_hit;
    logic             w_inc;

    assign w_hit     = edge_mode ? (event_in & ~r_prev) : event_in;
    // Clear and load both pre-empt the event, so neither may raise an overflow.
    assign w_inc     = count_en & w_hit & ~load & ~clr;
    assign ovf_pulse = w_inc & (&r_count);
    assign count     = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_count <= '0;
        end else begin
            r_prev <= event_in;
            if (clr) begin
                r_count <= '0;
            end else if (load) begin
                r_count <= load_data;
            end else if (w_inc) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/soc_perf_counter_bank.sv
// ============================================================================
// Module   : soc_perf_counter_bank
// Purpose  : Bank of NUM_CH event counters with register access, overflow flags and irq.
//            Snapshot registers built only when PERF_SNAPSHOT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module soc_perf_counter_bank
    import soc_perf_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        address,
    input  logic              write,
    input  logic [31:0]       write_data,
    input  logic              read,
    output logic [31:0]       read_data,
    output logic              read_valid,
    input  logic [NUM_CH-1:0] event_in,
    output logic              irq
);

    logic              r_gen;
    logic [NUM_CH-1:0] r_enable;
    logic [NUM_CH-1:0] r_mode;
    logic [NUM_CH-1:0] r_ovf;
    logic [NUM_CH-1:0] r_irq_mask;
    logic              r_irq;
    logic [31:0]       r_read_data;
    logic              r_read_valid;

    logic [CNT_W-1:0]  w_count [NUM_CH];
    logic [NUM_CH-1:0] w_ovf_set;
    logic [NUM_CH-1:0] w_ovf_w1c;
    ctrl_reg_t         w_ctrl_wr;
    ctrl_reg_t         w_ctrl_rd;
    logic              w_wr_ctrl;
    logic              w_clr;
    logic [31:0]       w_rd_data;

    assign w_ctrl_wr = ctrl_reg_t'(write_data[c_ctrl_clr_bit:c_ctrl_gen_bit]);
    assign w_ctrl_rd = '{clr: 1'b0, snap: 1'b0, gen: r_gen};
    assign w_wr_ctrl = write && (address == c_addr_ctrl);
    assign w_clr     = w_wr_ctrl && w_ctrl_wr.clr;
    assign w_ovf_w1c = (write && (address == c_addr_ovf)) ? write_data[NUM_CH-1:0] : '0;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic w_load;
        assign w_load = write && (address == c_addr_count_base + 9'(ch));

        perf_counter_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .event_in  (event_in[ch]),
            .count_en  (r_gen & r_enable[ch]),
            .edge_mode (r_mode[ch]),
            .load      (w_load),
            .load_data (write_data[CNT_W-1:0]),
            .clr       (w_clr),
            .count     (w_count[ch]),
            .ovf_pulse (w_ovf_set[ch])
        );
    end

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_W-1:0] r_snap [NUM_CH];
    logic             w_snap;

    assign w_snap = w_wr_ctrl && w_ctrl_wr.snap;

    // Captures the counter registers before this cycle's increment lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) r_snap[i] <= '0;
        end else if (w_snap) begin
            for (int i = 0; i < NUM_CH; i++) r_snap[i] <= w_count[i];
        end
    end
`endif

    always_comb begin
        w_rd_data = '0;
        case (address)
            c_addr_ctrl:     w_rd_data = 32'(w_ctrl_rd);
            c_addr_enable:   w_rd_data = 32'(r_enable);
            c_addr_mode:     w_rd_data = 32'(r_mode);
            c_addr_ovf:      w_rd_data = 32'(r_ovf);
            c_addr_irq_mask: w_rd_data = 32'(r_irq_mask);
            c_addr_id:       w_rd_data = {c_id_magic, 8'(CNT_W), 8'(NUM_CH)};
            default: begin
                for (int ch = 0; ch < NUM_CH; ch++) begin
                    if (address == c_addr_count_base + 9'(ch)) w_rd_data = 32'(w_count[ch]);
`ifdef PERF_SNAPSHOT_EN
                    if (address == c_addr_snap_base + 9'(ch)) w_rd_data = 32'(r_snap[ch]);
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gen        <= 1'b0;
            r_enable     <= '0;
            r_mode       <= '0;
            r_ovf        <= '0;
            r_irq_mask   <= '0;
            r_irq        <= 1'b0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end else begin
            if (w_wr_ctrl) r_gen <= w_ctrl_wr.gen;
            if (write && (address == c_addr_enable))   r_enable   <= write_data[NUM_CH-1:0];
            if (write && (address == c_addr_mode))     r_mode     <= write_data[NUM_CH-1:0];
            if (write && (address == c_addr_irq_mask)) r_irq_mask <= write_data[NUM_CH-1:0];
            // A new overflow outranks a simultaneous write-1-to-clear of the same flag.
            r_ovf        <= w_clr ? '0 : ((r_ovf & ~w_ovf_w1c) | w_ovf_set);
            r_irq        <= |(r_ovf & r_irq_mask);
            r_read_valid <= read;
            if (read) r_read_data <= w_rd_data;
        end
    end

    assign read_data  = r_read_data;
    assign read_valid = r_read_valid;
    assign irq        = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_soc_perf_counter_bank.sv
// ============================================================================
// Module   : tb_soc_perf_counter_bank
// Purpose  : Scoreboard bench for soc_perf_counter_bank against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_soc_perf_counter_bank;

    localparam int     NUM_CH = 8;
    localparam int     CNT_W  = 32;
    localparam longint MAXV   = (longint'(1) << CNT_W) - 1;
`ifdef PERF_SNAPSHOT_EN
    localparam logic [31:0] c_snap_exp = 32'd5;
`else
    localparam logic [31:0] c_snap_exp = 32'd0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [8:0]        address;
    logic              write;
    logic [31:0]       write_data;
    logic              read;
    logic [31:0]       read_data;
    logic              read_valid;
    logic [NUM_CH-1:0] event_in;
    logic              irq;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    longint            m_cnt  [NUM_CH];
    longint            m_snap [NUM_CH];
    bit                m_gen;
    bit [NUM_CH-1:0]   m_en, m_mode, m_ovf, m_mask, m_prev;
    bit                m_irq;

    soc_perf_counter_bank #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write      (write),
        .write_data (write_data),
        .read       (read),
        .read_data  (read_data),
        .read_valid (read_valid),
        .event_in   (event_in),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cnt[i]  = 0;
            m_snap[i] = 0;
        end
        m_gen = 0; m_en = '0; m_mode = '0; m_ovf = '0; m_mask = '0; m_prev = '0; m_irq = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [8:0] a);
        int idx = int'(a);
        if (idx == 0) return {31'd0, m_gen};
        if (idx == 1) return 32'(m_en);
        if (idx == 2) return 32'(m_mode);
        if (idx == 3) return 32'(m_ovf);
        if (idx == 4) return 32'(m_mask);
        if (idx == 5) return {16'h5043, 8'(CNT_W), 8'(NUM_CH)};
        if (idx >= 16 && idx < 16 + NUM_CH) return 32'(m_cnt[idx-16]);
`ifdef PERF_SNAPSHOT_EN
        if (idx >= 32 && idx < 32 + NUM_CH) return 32'(m_snap[idx-32]);
`endif
        return 32'd0;
    endfunction

    // Advances the model by one clock edge using the register-map rules directly.
    task automatic model_step(input logic [8:0] a, input logic wr, input logic [31:0] wd,
                              input logic [NUM_CH-1:0] ev);
        bit [NUM_CH-1:0] set_v = '0;
        bit [NUM_CH-1:0] w1c   = '0;
        bit clr, snap, hit;
        int idx = int'(a);
        m_irq = |(m_ovf & m_mask);
        clr   = wr && idx == 0 && wd[2];
        snap  = wr && idx == 0 && wd[1];
        for (int ch = 0; ch < NUM_CH; ch++) begin
            hit = m_mode[ch] ? (ev[ch] && !m_prev[ch]) : ev[ch];
`ifdef PERF_SNAPSHOT_EN
            if (snap) m_snap[ch] = m_cnt[ch];
`endif
            if (clr) m_cnt[ch] = 0;
            else if (wr && idx == 16 + ch) m_cnt[ch] = longint'(wd) & MAXV;
            else if (m_gen && m_en[ch] && hit) begin
                if (m_cnt[ch] == MAXV) begin
                    m_cnt[ch] = 0;
                    set_v[ch] = 1'b1;
                end else begin
                    m_cnt[ch] = m_cnt[ch] + 1;
                end
            end
        end
        if (wr && idx == 3) w1c = wd[NUM_CH-1:0];
        m_ovf = clr ? '0 : ((m_ovf & ~w1c) | set_v);
        if (wr && idx == 0) m_gen  = wd[0];
        if (wr && idx == 1) m_en   = wd[NUM_CH-1:0];
        if (wr && idx == 2) m_mode = wd[NUM_CH-1:0];
        if (wr && idx == 4) m_mask = wd[NUM_CH-1:0];
        m_prev = ev;
    endtask

    task automatic step(input logic [8:0] a, input logic wr, input logic [31:0] wd,
                        input logic rd, input logic [NUM_CH-1:0] ev,
                        input string nm = "rd", input bit use_exp = 0,
                        input logic [31:0] ex = 32'd0);
        address = a; write = wr; write_data = wd; read = rd; event_in = ev;
        if (rd) begin
            exp_q.push_back(use_exp ? ex : model_read(a));
            name_q.push_back(nm);
        end
        model_step(a, wr, wd, ev);
        @(posedge clk);
        #1;
        chk("irq", 32'(irq), 32'(m_irq));
        write = 1'b0; read = 1'b0;
    endtask

    task automatic wr_reg(input logic [8:0] a, input logic [31:0] d);
        step(a, 1'b1, d, 1'b0, '0);
    endtask

    task automatic rd_chk(input logic [8:0] a, input logic [31:0] ex, input string nm);
        step(a, 1'b0, 32'd0, 1'b1, '0, nm, 1'b1, ex);
    endtask

    task automatic idle(input int n);
        repeat (n) step(9'h000, 1'b0, 32'd0, 1'b0, '0);
    endtask

    // Monitor: every presented read result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (read_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_read_valid", 32'd1, 32'd0);
            end else begin
                chk(name_q.pop_front(), read_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: got stalled expected finish");
        $fatal(1);
    end

    initial begin
        logic [8:0] addrs [24];
        logic [8:0] a;
        logic [31:0] wd;
        for (int i = 0; i < 10; i++) addrs[i] = 9'h010 + 9'(i);
        for (int i = 0; i < 8; i++)  addrs[10+i] = 9'h020 + 9'(i);
        addrs[18] = 9'h000; addrs[19] = 9'h001; addrs[20] = 9'h002;
        addrs[21] = 9'h003; addrs[22] = 9'h004; addrs[23] = 9'h005;

        reset = 1'b1; address = '0; write = 0; write_data = '0; read = 0; event_in = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_read_valid", 32'(read_valid), 32'd0);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        rd_chk(9'h000, 32'd0, "rst_ctrl");
        rd_chk(9'h013, 32'd0, "rst_cnt3");

        // Level counting on channel 0.
        wr_reg(9'h001, 32'h01); wr_reg(9'h002, 32'h00); wr_reg(9'h000, 32'h01);
        repeat (10) step(9'h000, 1'b0, 32'd0, 1'b0, 8'h01);
        rd_chk(9'h010, 32'd10, "cnt0_level");
        rd_chk(9'h011, 32'd0, "cnt1_idle");

        // Edge counting on channel 1.
        wr_reg(9'h001, 32'h03); wr_reg(9'h002, 32'h02);
        repeat (3) begin
            repeat (10) step(9'h000, 1'b0, 32'd0, 1'b0, 8'h02);
            repeat (10) step(9'h000, 1'b0, 32'd0, 1'b0, 8'h00);
        end
        rd_chk(9'h011, 32'd3, "cnt1_edge");
        rd_chk(9'h010, 32'd10, "cnt0_hold");

        // Wrap, overflow, irq and write-1-to-clear on channel 2.
        wr_reg(9'h004, 32'h04); wr_reg(9'h001, 32'h07); wr_reg(9'h012, 32'hFFFF_FFFE);
        repeat (3) step(9'h000, 1'b0, 32'd0, 1'b0, 8'h04);
        rd_chk(9'h012, 32'd1, "cnt2_wrap");
        rd_chk(9'h003, 32'h04, "ovf2_set");
        chk("irq_high", 32'(irq), 32'd1);
        wr_reg(9'h003, 32'h04);
        idle(1);
        chk("irq_low", 32'(irq), 32'd0);
        rd_chk(9'h003, 32'd0, "ovf2_w1c");
        wr_reg(9'h012, 32'hFFFF_FFFF);
        step(9'h003, 1'b1, 32'h04, 1'b0, 8'h04);
        rd_chk(9'h003, 32'h04, "ovf_set_beats_w1c");
        wr_reg(9'h003, 32'h04);
        step(9'h012, 1'b1, 32'd100, 1'b0, 8'h04);
        rd_chk(9'h012, 32'd100, "load_beats_event");

        // Snapshot under a continuous event on channel 0.
        step(9'h010, 1'b1, 32'd5, 1'b0, 8'h01);
        step(9'h000, 1'b1, 32'h3, 1'b0, 8'h01);
        step(9'h020, 1'b0, 32'd0, 1'b1, 8'h01, "snap0", 1'b1, c_snap_exp);
        step(9'h010, 1'b0, 32'd0, 1'b1, 8'h01, "cnt0_after_snap", 1'b1, 32'd7);
        rd_chk(9'h000, 32'd1, "ctrl_selfclear");

        wr_reg(9'h000, 32'h5);
        rd_chk(9'h010, 32'd0, "clr_cnt0");
        rd_chk(9'h012, 32'd0, "clr_cnt2");

        rd_chk(9'h005, 32'h5043_2008, "id");
        rd_chk(9'h01F, 32'd0, "unmapped_ch15");
        wr_reg(9'h018, 32'd123);
        rd_chk(9'h018, 32'd0, "ch8_ignored");
        rd_chk(9'h100, 32'd0, "unmapped_high");
        step(9'h001, 1'b1, 32'hAA, 1'b1, '0, "rw_old_enable", 1'b1, 32'h07);
        rd_chk(9'h001, 32'hAA, "rw_new_enable");

        repeat (400) begin
            a = addrs[$urandom_range(0, 23)];
            if (a == 9'h000)
                wd = 32'($urandom_range(0, 7)) | 32'(($urandom_range(0, 3) != 0) ? 1 : 0);
            else if (a >= 9'h010 && a < 9'h020 && $urandom_range(0, 1) == 1)
                wd = 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
            else
                wd = $urandom;
            step(a, ($urandom_range(0, 3) == 0), wd, 1'($urandom_range(0, 1)),
                 NUM_CH'($urandom), "rand_read");
        end
        idle(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset lands while a read strobe is on the bus.
        wr_reg(9'h001, 32'hFF); wr_reg(9'h004, 32'hFF); wr_reg(9'h000, 32'h01);
        repeat (5) step(9'h000, 1'b0, 32'd0, 1'b0, 8'hFF);
        address = 9'h010; read = 1'b1; event_in = 8'hFF;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_read_valid", 32'(read_valid), 32'd0);
        chk("rst_mid_read_data", read_data, 32'd0);
        chk("rst_mid_irq", 32'(irq), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        read = 1'b0; event_in = '0;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("no_valid_after_reset", 32'(read_valid), 32'd0);
        end
        rd_chk(9'h010, 32'd0, "cnt0_after_reset");
        rd_chk(9'h001, 32'd0, "enable_after_reset");
        idle(2);
        chk("queue_drained_end", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
